alu_issue_buf: RTL and testbench
================================

ALU_ISSUE_BUF -- requirements
Module: alu_issue_buf

Interface
REQ-001 The block SHALL sit directly upstream of the ALU, buffering operand/op bundles from decode and presenting them registered to the ALU inputs (alu_op, in_a, in_b).
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Parameter: CNT_W, default 16, width of the stall-cycle counter.
REQ-004 Port: clk  input  1  clock; all state updates on rising edge.
REQ-005 Port: rst  input  1  synchronous active-high reset.
REQ-006 Port: in_valid  input  1  upstream bundle valid.
REQ-007 Port: in_ready  output  1  block can accept a bundle this cycle.
REQ-008 Port: in_alu_op  input  alu_op_t  operation from riscv_32i_defs_pkg.
REQ-009 Port: in_a / in_b  input  word_t (32)  operands.
REQ-010 Port: flush  input  1  discard all buffered bundles (branch/redirect).
REQ-011 Port: out_valid  output  1  bundle presented to ALU is valid.
REQ-012 Port: out_ready  input  1  downstream consumes bundle this cycle.
REQ-013 Port: out_alu_op  output  alu_op_t; out_a / out_b  output  word_t  registered bundle to ALU.
REQ-014 Port: occupancy  output  2  number of held bundles (0..2).
REQ-015 Port: stall_cnt  output  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-016 Storage SHALL be two entries: MAIN (drives out_*) and SKID; state machine EMPTY, ONE, TWO; occupancy = 0/1/2 respectively.
REQ-017 in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
REQ-018 in_ready SHALL be 1 in EMPTY and ONE, 0 in TWO, and 0 while rst is high.
REQ-019 out_valid SHALL be 1 in ONE and TWO, 0 in EMPTY.
REQ-020 EMPTY: in_fire -> MAIN<=input, ONE; else stay EMPTY.
REQ-021 ONE: in_fire & !out_fire -> SKID<=input, TWO; in_fire & out_fire -> MAIN<=input, ONE; !in_fire & out_fire -> EMPTY; neither -> ONE, hold.
REQ-022 TWO: out_fire -> MAIN<=SKID, ONE; else hold.
REQ-023 Latency: a bundle accepted in EMPTY SHALL appear on out_* with out_valid=1 the next cycle; no combinational path from in_* to out_*.
REQ-024 Ordering SHALL be strict FIFO; no bundle dropped or duplicated except by flush.
REQ-025 out_alu_op/out_a/out_b SHALL remain stable while out_valid=1 and out_ready=0.
REQ-026 flush=1 SHALL force EMPTY next cycle, discarding MAIN, SKID and any same-cycle in_fire; an out_fire in the flush cycle counts as consumed.
REQ-027 Data registers SHALL NOT be cleared by flush; only state changes.
REQ-028 stall_cnt SHALL increment by 1 each cycle out_valid=1 & out_ready=0, saturate at 2^CNT_W-1, never wrap; flush does not clear it.

Reset
REQ-029 rst=1 SHALL force state EMPTY, out_valid=0, occupancy=0, stall_cnt=0, out_alu_op/out_a/out_b=0; in_ready=1 first cycle after rst deasserts.
REQ-030 rst SHALL take priority over flush and all handshakes; reset mid-operation discards all held bundles.

Verification
REQ-031 Reset, then in_valid=1, in_a=0x0000_0005, in_b=0x0000_0003, out_ready=1 -> next cycle out_valid=1, out_a=0x5, out_b=0x3, occupancy=1.
REQ-032 out_ready=0, push A=0x11 then B=0x22 -> occupancy=2, in_ready=0, out_a=0x11 stable; release out_ready -> out_a 0x11 then 0x22, in_ready=1 after first pop.
REQ-033 occupancy=1, simultaneous push 0x33 and pop -> occupancy stays 1, out_a=0x33 next cycle.
REQ-034 occupancy=2, flush=1 with in_valid=1 -> next cycle out_valid=0, occupancy=0, flushed-cycle input never appears.
REQ-035 CNT_W=4, hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays 15.
REQ-036 occupancy=2, rst pulse one cycle -> out_valid=0, stall_cnt=0, out_a=0, in_ready=1 following cycle.

Source files
------------

// File: rtl/alu_issue_buf.sv
// Two-entry (MAIN + SKID) issue buffer in front of the ALU: registered bundle
// outputs, strict FIFO order, flush to empty, and a saturating stall counter.

package riscv_32i_defs_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_COPY_B = 4'd10
    } alu_op_t;
endpackage

module alu_issue_buf
    import riscv_32i_defs_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  alu_op_t          in_alu_op,
    input  word_t            in_a,
    input  word_t            in_b,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output alu_op_t          out_alu_op,
    output word_t            out_a,
    output word_t            out_b,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state_reg;
    alu_op_t          main_op_reg;
    word_t            main_a_reg;
    word_t            main_b_reg;
    alu_op_t          skid_op_reg;
    word_t            skid_a_reg;
    word_t            skid_b_reg;
    logic [CNT_W-1:0] stall_cnt_reg;

    logic in_fire;
    logic out_fire;

    assign in_ready   = !rst && (state_reg != TWO);
    assign out_valid  = (state_reg != EMPTY);
    assign in_fire    = in_valid && in_ready;
    assign out_fire   = out_valid && out_ready;
    assign occupancy  = state_reg;
    assign out_alu_op = main_op_reg;
    assign out_a      = main_a_reg;
    assign out_b      = main_b_reg;
    assign stall_cnt  = stall_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= EMPTY;
            main_op_reg   <= ALU_ADD;
            main_a_reg    <= '0;
            main_b_reg    <= '0;
            skid_op_reg   <= ALU_ADD;
            skid_a_reg    <= '0;
            skid_b_reg    <= '0;
            stall_cnt_reg <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_cnt_reg != '1))
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);

            // Flush only drops the state; payload registers keep stale data.
            if (flush) begin
                state_reg <= EMPTY;
            end else begin
                case (state_reg)
                    EMPTY: begin
                        if (in_fire) begin
                            main_op_reg <= in_alu_op;
                            main_a_reg  <= in_a;
                            main_b_reg  <= in_b;
                            state_reg   <= ONE;
                        end
                    end
                    ONE: begin
                        if (in_fire && !out_fire) begin
                            skid_op_reg <= in_alu_op;
                            skid_a_reg  <= in_a;
                            skid_b_reg  <= in_b;
                            state_reg   <= TWO;
                        end else if (in_fire && out_fire) begin
                            main_op_reg <= in_alu_op;
                            main_a_reg  <= in_a;
                            main_b_reg  <= in_b;
                        end else if (out_fire) begin
                            state_reg <= EMPTY;
                        end
                    end
                    TWO: begin
                        if (out_fire) begin
                            main_op_reg <= skid_op_reg;
                            main_a_reg  <= skid_a_reg;
                            main_b_reg  <= skid_b_reg;
                            state_reg   <= ONE;
                        end
                    end
                    default: state_reg <= EMPTY;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_buf.sv
// Bench for alu_issue_buf: a queue-based reference model tracks held bundles and
// stall cycles; directed scenarios plus a randomized run compare against it.

module tb_alu_issue_buf;
    import riscv_32i_defs_pkg::*;

    typedef struct {
        alu_op_t op;
        word_t   a;
        word_t   b;
    } bundle_t;

    logic    clk = 1'b0;
    logic    rst;
    logic    in_valid;
    alu_op_t in_alu_op;
    word_t   in_a;
    word_t   in_b;
    logic    flush;
    logic    out_ready;

    logic        in_ready, out_valid;
    alu_op_t     out_alu_op;
    word_t       out_a, out_b;
    logic [1:0]  occupancy;
    logic [15:0] stall_cnt;

    logic        in_ready4, out_valid4;
    alu_op_t     out_alu_op4;
    word_t       out_a4, out_b4;
    logic [1:0]  occupancy4;
    logic [3:0]  stall_cnt4;

    int checks = 0;
    int failures = 0;

    bundle_t     mq[$];
    int unsigned stall_total;

    always #5 clk = ~clk;

    alu_issue_buf dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_op(in_alu_op), .in_a(in_a), .in_b(in_b), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_alu_op(out_alu_op),
        .out_a(out_a), .out_b(out_b), .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    alu_issue_buf #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .in_alu_op(in_alu_op), .in_a(in_a), .in_b(in_b), .flush(flush),
        .out_valid(out_valid4), .out_ready(out_ready), .out_alu_op(out_alu_op4),
        .out_a(out_a4), .out_b(out_b4), .occupancy(occupancy4), .stall_cnt(stall_cnt4)
    );

    function automatic int unsigned sat(int unsigned v, int unsigned mx);
        return (v > mx) ? mx : v;
    endfunction

    // Drive one cycle's inputs, then wait to mid-cycle for sampling.
    task automatic apply(input logic v, input word_t a, input word_t b, input alu_op_t op,
                         input logic ordy, input logic fl, input logic r);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_alu_op = op;
        out_ready = ordy;
        flush     = fl;
        rst       = r;
        @(negedge clk);
    endtask

    // Clock edge: advance the reference model from the inputs held this cycle.
    task automatic advance();
        bundle_t nb;
        bit      ovalid, irdy, ofire, ifire;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            stall_total = 0;
        end else begin
            ovalid = (mq.size() > 0);
            irdy   = (mq.size() < 2);
            ofire  = ovalid && out_ready;
            ifire  = in_valid && irdy;
            if (ovalid && !out_ready) stall_total++;
            if (flush) begin
                mq.delete();
            end else begin
                if (ofire) void'(mq.pop_front());
                if (ifire) begin
                    nb.op = in_alu_op;
                    nb.a  = in_a;
                    nb.b  = in_b;
                    mq.push_back(nb);
                end
            end
        end
        #1;
    endtask

    task automatic idle(input logic ordy);
        apply(1'b0, '0, '0, ALU_ADD, ordy, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        apply(1'b1, 32'hDEAD, 32'hBEEF, ALU_SUB, 1'b0, 1'b0, 1'b1);
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_ready_during got=%b exp=0", in_ready);
        end
        advance();
        apply(1'b1, 32'hDEAD, 32'hBEEF, ALU_SUB, 1'b0, 1'b0, 1'b1);
        advance();
        idle(1'b0);
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_state got v=%b occ=%0d rdy=%b exp v=0 occ=0 rdy=1",
                     out_valid, occupancy, in_ready);
        end
        checks++;
        if (out_a !== 32'h0 || out_b !== 32'h0 || out_alu_op !== alu_op_t'(0)
            || stall_cnt !== 16'd0 || stall_cnt4 !== 4'd0) begin
            failures++;
            $display("FAIL reset_data got a=%h b=%h op=%0d st=%0d st4=%0d exp all 0",
                     out_a, out_b, out_alu_op, stall_cnt, stall_cnt4);
        end
        advance();
        $display("test_reset done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_single();
        apply(1'b1, 32'h5, 32'h3, ALU_ADD, 1'b1, 1'b0, 1'b0);
        advance();
        idle(1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_a !== 32'h5 || out_b !== 32'h3 || occupancy !== 2'd1) begin
            failures++;
            $display("FAIL single_latency got v=%b a=%h b=%h occ=%0d exp v=1 a=5 b=3 occ=1",
                     out_valid, out_a, out_b, occupancy);
        end
        advance();
        $display("test_single done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_skid();
        apply(1'b1, 32'h11, 32'h1, ALU_OR, 1'b0, 1'b0, 1'b0);
        advance();
        apply(1'b1, 32'h22, 32'h2, ALU_AND, 1'b0, 1'b0, 1'b0);
        advance();
        for (int i = 0; i < 2; i++) begin
            idle(1'b0);
            checks++;
            if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_a !== 32'h11 || out_alu_op !== ALU_OR) begin
                failures++;
                $display("FAIL skid_full_%0d got occ=%0d rdy=%b a=%h op=%0d exp occ=2 rdy=0 a=11 op=%0d",
                         i, occupancy, in_ready, out_a, out_alu_op, ALU_OR);
            end
            advance();
        end
        idle(1'b1);
        checks++;
        if (out_a !== 32'h11) begin
            failures++;
            $display("FAIL skid_pop1 got a=%h exp a=11", out_a);
        end
        advance();
        idle(1'b1);
        checks++;
        if (out_a !== 32'h22 || out_alu_op !== ALU_AND || in_ready !== 1'b1 || occupancy !== 2'd1) begin
            failures++;
            $display("FAIL skid_pop2 got a=%h op=%0d rdy=%b occ=%0d exp a=22 op=%0d rdy=1 occ=1",
                     out_a, out_alu_op, in_ready, occupancy, ALU_AND);
        end
        advance();
        $display("test_skid done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_simul();
        apply(1'b1, 32'h44, 32'h4, ALU_XOR, 1'b0, 1'b0, 1'b0);
        advance();
        apply(1'b1, 32'h33, 32'h3, ALU_SLL, 1'b1, 1'b0, 1'b0);
        checks++;
        if (occupancy !== 2'd1 || out_a !== 32'h44) begin
            failures++;
            $display("FAIL simul_before got occ=%0d a=%h exp occ=1 a=44", occupancy, out_a);
        end
        advance();
        idle(1'b1);
        checks++;
        if (occupancy !== 2'd1 || out_a !== 32'h33 || out_alu_op !== ALU_SLL) begin
            failures++;
            $display("FAIL simul_after got occ=%0d a=%h op=%0d exp occ=1 a=33 op=%0d",
                     occupancy, out_a, out_alu_op, ALU_SLL);
        end
        advance();
        $display("test_simul done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_flush();
        apply(1'b1, 32'h55, 32'h5, ALU_ADD, 1'b0, 1'b0, 1'b0);
        advance();
        apply(1'b1, 32'h66, 32'h6, ALU_ADD, 1'b0, 1'b0, 1'b0);
        advance();
        apply(1'b1, 32'h99, 32'h9, ALU_SRA, 1'b0, 1'b1, 1'b0);
        advance();
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            checks++;
            if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL flush_empty_%0d got v=%b occ=%0d rdy=%b a=%h exp v=0 occ=0 rdy=1",
                         i, out_valid, occupancy, in_ready, out_a);
            end
            advance();
        end
        $display("test_flush done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_stall_sat();
        apply(1'b1, 32'h77, 32'h7, ALU_SUB, 1'b0, 1'b0, 1'b0);
        advance();
        for (int i = 0; i < 20; i++) begin
            idle(1'b0);
            checks++;
            if (stall_cnt4 !== 4'(sat(stall_total, 15)) || stall_cnt !== 16'(sat(stall_total, 65535))) begin
                failures++;
                $display("FAIL stall_cyc%0d got st4=%0d st=%0d exp st4=%0d st=%0d",
                         i, stall_cnt4, stall_cnt, sat(stall_total, 15), sat(stall_total, 65535));
            end
            advance();
        end
        idle(1'b1);
        checks++;
        if (stall_cnt4 !== 4'd15 || out_a4 !== 32'h77) begin
            failures++;
            $display("FAIL stall_saturated got st4=%0d a4=%h exp st4=15 a4=77", stall_cnt4, out_a4);
        end
        advance();
        $display("test_stall_sat done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_random();
        bit    v, ordy, fl, r;
        word_t a, b;
        for (int cyc = 0; cyc < 400; cyc++) begin
            v    = ($urandom_range(0, 99) < 60);
            ordy = ($urandom_range(0, 99) < 50);
            fl   = ($urandom_range(0, 99) < 5);
            r    = ($urandom_range(0, 99) < 2);
            a    = $urandom();
            b    = $urandom();
            apply(v, a, b, alu_op_t'($urandom_range(0, 10)), ordy, fl, r);
            checks++;
            if (in_ready !== (!r && mq.size() < 2) || out_valid !== (mq.size() > 0)
                || occupancy !== 2'(mq.size())) begin
                failures++;
                $display("FAIL rnd_ctrl cyc=%0d got rdy=%b v=%b occ=%0d exp rdy=%b v=%b occ=%0d",
                         cyc, in_ready, out_valid, occupancy, (!r && mq.size() < 2),
                         (mq.size() > 0), mq.size());
            end
            if (mq.size() > 0) begin
                checks++;
                if (out_a !== mq[0].a || out_b !== mq[0].b || out_alu_op !== mq[0].op) begin
                    failures++;
                    $display("FAIL rnd_data cyc=%0d got a=%h b=%h op=%0d exp a=%h b=%h op=%0d",
                             cyc, out_a, out_b, out_alu_op, mq[0].a, mq[0].b, mq[0].op);
                end
            end
            checks++;
            if (stall_cnt !== 16'(sat(stall_total, 65535)) || stall_cnt4 !== 4'(sat(stall_total, 15))) begin
                failures++;
                $display("FAIL rnd_stall cyc=%0d got st=%0d st4=%0d exp st=%0d st4=%0d",
                         cyc, stall_cnt, stall_cnt4, sat(stall_total, 65535), sat(stall_total, 15));
            end
            advance();
        end
        $display("test_random done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_reset_mid();
        apply(1'b1, 32'hA1, 32'h1, ALU_ADD, 1'b0, 1'b0, 1'b0);
        advance();
        apply(1'b1, 32'hA2, 32'h2, ALU_ADD, 1'b0, 1'b0, 1'b0);
        advance();
        idle(1'b0);
        checks++;
        if (occupancy !== 2'd2 || stall_cnt === 16'd0) begin
            failures++;
            $display("FAIL rstmid_pre got occ=%0d st=%0d exp occ=2 st>0", occupancy, stall_cnt);
        end
        advance();
        apply(1'b1, 32'hA3, 32'h3, ALU_ADD, 1'b0, 1'b1, 1'b1);
        advance();
        idle(1'b0);
        checks++;
        if (out_valid !== 1'b0 || stall_cnt !== 16'd0 || out_a !== 32'h0 || in_ready !== 1'b1
            || occupancy !== 2'd0) begin
            failures++;
            $display("FAIL rstmid_post got v=%b st=%0d a=%h rdy=%b occ=%0d exp v=0 st=0 a=0 rdy=1 occ=0",
                     out_valid, stall_cnt, out_a, in_ready, occupancy);
        end
        advance();
        $display("test_reset_mid done checks=%0d failures=%0d", checks, failures);
    endtask

    initial begin
        mq.delete();
        stall_total = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_alu_op = ALU_ADD;
        flush = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_skid();
        test_simul();
        test_flush();
        test_stall_sat();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
